// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and constants for the writeback arbiter.
package regfile_pkg;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 4;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
    localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: busy bit per register for pending late writes, with
// same-cycle forwarding on lookups and set-over-clear priority.
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic                  rs_busy,
    output logic                  rt_busy
);
    logic [NUM_REGS-1:0] busy_q, busy_d, set_mask, clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        set_mask[set_addr] = set_en;
        clr_mask[clr_addr] = clr_en;
        busy_d = (busy_q & ~clr_mask) | set_mask;
        busy_d[ZERO_REG] = 1'b0;
        // A clear in this cycle is forwarded by the register file write.
        rs_busy = rst && busy_q[rs_addr] && !(clr_en && clr_addr == rs_addr);
        rt_busy = rst && busy_q[rt_addr] && !(clr_en && clr_addr == rt_addr);
    end

    always_ff @(posedge clk) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares one register-file write port between the in-order
// pipe and a late multi-cycle unit, stalling the pipe when the late unit starves.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we_i,
    input  logic [REG_ADDR_W-1:0] pipe_waddr_i,
    input  logic [DATA_W-1:0]     pipe_wdata_i,
    input  logic                  late_valid_i,
    input  logic [REG_ADDR_W-1:0] late_addr_i,
    input  logic [DATA_W-1:0]     late_data_i,
    output logic                  late_ready_o,
    input  logic                  issue_i,
    input  logic [REG_ADDR_W-1:0] issue_addr_i,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    output logic                  rs_busy_o,
    output logic                  rt_busy_o,
    output logic                  we_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  stall_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_q, stall_d;
    logic             pipe_eff, late_hs;

    always_comb begin
        pipe_eff = rst && pipe_we_i && (pipe_waddr_i != ZERO_REG) && !stall_q;
        late_hs  = rst && late_valid_i && !pipe_eff;
        we_o     = 1'b0;
        waddr_o  = ZERO_REG;
        wdata_o  = '0;
        if (pipe_eff) begin
            we_o    = 1'b1;
            waddr_o = pipe_waddr_i;
            wdata_o = pipe_wdata_i;
        end else if (late_hs && late_addr_i != ZERO_REG) begin
            we_o    = 1'b1;
            waddr_o = late_addr_i;
            wdata_o = late_data_i;
        end
        cnt_d   = (!late_valid_i || late_hs) ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Stall holds until the late request actually drains.
        stall_d = late_hs ? 1'b0 : (stall_q || cnt_d >= CNT_W'(STARVE_MAX));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign late_ready_o = late_hs;
    assign stall_o      = stall_q;

    reg_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_i),
        .set_addr (issue_addr_i),
        .clr_en   (late_hs),
        .clr_addr (late_addr_i),
        .rs_addr  (rs_addr_i),
        .rt_addr  (rt_addr_i),
        .rs_busy  (rs_busy_o),
        .rt_busy  (rt_busy_o)
    );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of arbitration, starvation stall,
// scoreboard forwarding and reset behaviour.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pipe_we_i = 1'b0;
    logic [4:0]  pipe_waddr_i = '0;
    logic [31:0] pipe_wdata_i = '0;
    logic        late_valid_i = 1'b0;
    logic [4:0]  late_addr_i = '0;
    logic [31:0] late_data_i = '0;
    logic        late_ready_o;
    logic        issue_i = 1'b0;
    logic [4:0]  issue_addr_i = '0;
    logic [4:0]  rs_addr_i = '0;
    logic [4:0]  rt_addr_i = '0;
    logic        rs_busy_o, rt_busy_o, we_o, stall_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    int          n_chk = 0;
    int          n_fail = 0;

    regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
        .late_valid_i(late_valid_i), .late_addr_i(late_addr_i), .late_data_i(late_data_i),
        .late_ready_o(late_ready_o),
        .issue_i(issue_i), .issue_addr_i(issue_addr_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rs_busy_o(rs_busy_o), .rt_busy_o(rt_busy_o),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
        pipe_we_i = we; pipe_waddr_i = a; pipe_wdata_i = d;
    endtask

    task automatic late(input logic v, input logic [4:0] a, input logic [31:0] d);
        late_valid_i = v; late_addr_i = a; late_data_i = d;
    endtask

    initial begin
        // reset: requests ignored, outputs quiet
        tick(); tick();
        pipe(1, 3, 32'h11); late(1, 5, 32'h22);
        issue_i = 1; issue_addr_i = 6; rs_addr_i = 6;
        #1;
        chk("rst_we", we_o, 0);
        chk("rst_late_ready", late_ready_o, 0);
        chk("rst_stall", stall_o, 0);
        tick();
        rst = 1; issue_i = 0; pipe(0, 0, 0); late(0, 0, 0);
        #1;
        chk("rst_issue_ignored", rs_busy_o, 0);
        // pipe priority, late follows when pipe idles
        tick();
        pipe(1, 3, 32'h11); late(1, 5, 32'h22);
        #1;
        chk("arb_we", we_o, 1);
        chk("arb_waddr", waddr_o, 3);
        chk("arb_wdata", wdata_o, 32'h11);
        chk("arb_late_ready0", late_ready_o, 0);
        tick();
        pipe(0, 0, 0);
        #1;
        chk("arb2_waddr", waddr_o, 5);
        chk("arb2_wdata", wdata_o, 32'h22);
        chk("arb2_late_ready", late_ready_o, 1);
        // starvation: stall after STARVE_MAX wait cycles
        tick();
        pipe(1, 7, 32'h77); late(1, 9, 32'h99);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("starve_stall0", stall_o, 0);
            chk("starve_ready0", late_ready_o, 0);
            chk("starve_waddr7", waddr_o, 7);
            tick();
        end
        #1;
        chk("starve_stall1", stall_o, 1);
        chk("starve_ready1", late_ready_o, 1);
        chk("starve_waddr9", waddr_o, 9);
        chk("starve_wdata", wdata_o, 32'h99);
        tick();
        late(0, 0, 0);
        #1;
        chk("starve_stall_clr", stall_o, 0);
        chk("starve_pipe_back", waddr_o, 7);
        // scoreboard set then forwarded clear
        tick();
        pipe(0, 0, 0); issue_i = 1; issue_addr_i = 12;
        tick();
        issue_i = 0; rs_addr_i = 12; rt_addr_i = 12;
        #1;
        chk("sb_rs_busy", rs_busy_o, 1);
        chk("sb_rt_busy", rt_busy_o, 1);
        tick();
        late(1, 12, 32'h5);
        #1;
        chk("sb_fwd_rs", rs_busy_o, 0);
        chk("sb_fwd_ready", late_ready_o, 1);
        tick();
        late(0, 0, 0);
        #1;
        chk("sb_cleared", rs_busy_o, 0);
        // set wins over clear on same address
        tick();
        issue_i = 1; issue_addr_i = 4;
        tick();
        late(1, 4, 32'h44); rs_addr_i = 4;
        #1;
        chk("sb_same_hs", late_ready_o, 1);
        tick();
        issue_i = 0; late(0, 0, 0);
        #1;
        chk("sb_set_wins", rs_busy_o, 1);
        issue_i = 1; issue_addr_i = 0;
        tick();
        issue_i = 0; rs_addr_i = 0;
        #1;
        chk("sb_zero", rs_busy_o, 0);
        // late to r0 completes without writing; pipe to r0 does not block it
        tick();
        pipe(1, 0, 32'hCD); late(1, 0, 32'hAB);
        #1;
        chk("r0_ready", late_ready_o, 1);
        chk("r0_we", we_o, 0);
        chk("r0_waddr", waddr_o, 0);
        chk("r0_wdata", wdata_o, 0);
        // reset mid-stall drops everything
        tick();
        pipe(1, 7, 32'h77); late(1, 9, 32'h99); rs_addr_i = 4;
        tick(); tick(); tick(); tick();
        #1;
        chk("rs_stall_set", stall_o, 1);
        chk("rs_busy_before", rs_busy_o, 1);
        rst = 0;
        #1;
        chk("rs_we0", we_o, 0);
        chk("rs_ready0", late_ready_o, 0);
        chk("rs_busy_in_rst", rs_busy_o, 0);
        tick();
        rst = 1;
        #1;
        chk("rs_stall_clr", stall_o, 0);
        chk("rs_busy_clr", rs_busy_o, 0);
        // counter restarted from zero: full STARVE_MAX wait again
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rs_cnt_stall0", stall_o, 0);
            tick();
        end
        #1;
        chk("rs_cnt_stall1", stall_o, 1);
        pipe(0, 0, 0); late(0, 0, 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, giving the cycles a late request may wait before the pipeline is stalled (range 1..15).
REQ-002 The block SHALL have port clk  input  1  clock, rising-edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have ports pipe_we_i / pipe_waddr_i / pipe_wdata_i  input  1/5/32  in-order writeback request; no backpressure.
REQ-005 The block SHALL have ports late_valid_i / late_addr_i / late_data_i  input  1/5/32  multi-cycle unit (divider, load miss) writeback request.
REQ-006 The block SHALL have port late_ready_o  output  1  late request granted this cycle.
REQ-007 The block SHALL have ports issue_i / issue_addr_i  input  1/5  late-unit operation issued; mark its destination busy.
REQ-008 The block SHALL have ports rs_addr_i / rt_addr_i  input  5/5  decode-stage source addresses.
REQ-009 The block SHALL have ports rs_busy_o / rt_busy_o  output  1/1  source has a pending late write.
REQ-010 The block SHALL have ports we_o / waddr_o / wdata_o  output  1/5/32  single register-file write port.
REQ-011 The block SHALL have port stall_o  output  1  registered; freezes the pipeline so the late unit can drain.

Function
REQ-012 A pipe request SHALL be effective when pipe_we_i=1, pipe_waddr_i!=0 and stall_o=0. While stall_o=1, pipe inputs SHALL be ignored; upstream holds them.
REQ-013 Grant: late_ready_o SHALL be late_valid_i && !(effective pipe request). The pipe has fixed priority unless stall_o=1.
REQ-014 Write port SHALL be combinational, same cycle: an effective pipe request drives the pipe fields; otherwise a granted late request with late_addr_i!=0 drives the late fields; otherwise we_o=0, waddr_o=0, wdata_o=0.
REQ-015 A granted late request to address 0 SHALL complete the handshake with we_o=0.
REQ-016 Wait counter: increment (saturating at 15) each cycle late_valid_i=1 and late_ready_o=0; clear on a late handshake or when late_valid_i=0.
REQ-017 stall_o SHALL be set on the clock edge where the counter's next value reaches STARVE_MAX, and cleared on the edge following the late handshake. Worst-case late latency = STARVE_MAX+1 cycles.
REQ-018 Scoreboard: 32 busy bits. Bit 0 SHALL always read 0. issue_i sets busy[issue_addr_i]. A late handshake clears busy[late_addr_i].
REQ-019 If a set and a clear hit the same address in the same cycle, set SHALL win.
REQ-020 rs_busy_o SHALL be busy[rs_addr_i] && !(late handshake this cycle with late_addr_i==rs_addr_i), because the register file forwards the same-cycle write. The same rule applies to rt_busy_o.
REQ-021 A pipe write to a busy address SHALL be performed and SHALL NOT change busy. Issuing to an already busy address SHALL leave it busy. Decode must stall on busy; this is not checked.
REQ-022 late_ready_o SHALL depend on late_valid_i only combinationally, with no registered grant state.

Reset
REQ-023 While rst=0 at a rising edge: all busy bits=0, counter=0, stall_o=0.
REQ-024 During reset, we_o SHALL be 0, late_ready_o 0, rs_busy_o/rt_busy_o 0; all requests are ignored.
REQ-025 Reset asserted mid-wait or mid-stall SHALL drop the pending late request without writing; the requester re-presents it after reset.

Structure
REQ-026 Package regfile_pkg SHALL hold REG_ADDR_W=5, NUM_REGS=32, DATA_W=32 and the zero-register constant.
REQ-027 The 32-bit busy vector with set/clear/lookup logic SHALL be sub-module reg_scoreboard. Arbitration, counter and stall stay in the top.

Verification
REQ-028 pipe_we=1 addr 3 data 0x11 with late_valid addr 5 data 0x22 for 1 cycle -> we_o/waddr_o=3/wdata_o=0x11, late_ready_o=0; next cycle with the pipe idle -> waddr_o=5, wdata_o=0x22, late_ready_o=1.
REQ-029 Pipe writes every cycle to addr 7, late_valid addr 9 held, STARVE_MAX=4 -> stall_o rises after 4 wait cycles; next cycle late_ready_o=1, waddr_o=9; stall_o low one cycle later.
REQ-030 issue addr 12, then rs_addr=12 -> rs_busy_o=1; late handshake addr 12 -> rs_busy_o=0 in the handshake cycle and after.
REQ-031 issue addr 4 in the same cycle as a late handshake to addr 4 -> busy[4] remains 1; issue addr 0 -> rs_busy_o=0 for rs_addr=0.
REQ-032 Late request to addr 0 -> late_ready_o=1, we_o=0; pipe_we to addr 0 with late pending -> late granted the same cycle.
REQ-033 Busy bits set and stall_o=1, then rst=0 for 1 cycle -> all busy=0, stall_o=0, counter=0, we_o=0.
